// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: ring-buffer FIFO feeding a start/data/stop serializer.
// Bytes are sent LSB first and back-to-back while the FIFO holds data.
module uart_tx_buf #(
  parameter int clk_freq  = 12000000,
  parameter int baud      = 115200,
  parameter int tbuf_size = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       put,
  input  logic [7:0] data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       TX
);

  localparam int DIV = clk_freq / baud;
  localparam int AW  = $clog2(tbuf_size);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [PW-1:0] DEPTH    = PW'(tbuf_size);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [PW-1:0] b_q, e_q;
  logic          tx_q, tx_d;
  logic [7:0]    shift_q;
  logic [7:0]    mem [tbuf_size];
  logic          pop, shift_en, wr_en;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (b_q == e_q);
  assign full  = ((e_q - b_q) == DEPTH);
  assign wr_en = put & ~full;
  assign busy  = (state_q != IDLE);
  assign TX    = tx_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    pop      = 1'b0;
    shift_en = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // The line level is precomputed from the next state so TX can be a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_en ? shift_q[1] : shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      b_q     <= '0;
      e_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      if (pop)   b_q <= b_q + 1'b1;
      if (wr_en) e_q <= e_q + 1'b1;
    end
  end

  // Buffer RAM with the shift register acting as its registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[e_q[AW-1:0]] <= data;
    if (pop)           shift_q <= mem[b_q[AW-1:0]];
    else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
  end

endmodule
